// File: rtl/alu_driver.sv
// Initiator side of the ALU command interface: folds calculator tokens into a signed
// accumulator, issuing one ALU op per "acc op number" triple. Optional macro: DIV0_CHECK_EN.
`ifndef AC_N
`define AC_N 2
`endif
`ifndef AC_AD
`define AC_AD 2'd0
`endif
`ifndef AC_SB
`define AC_SB 2'd1
`endif
`ifndef AC_MU
`define AC_MU 2'd2
`endif
`ifndef AC_DI
`define AC_DI 2'd3
`endif

module alu_driver #(
  parameter int N = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic [1:0]       tok_type,
  input  logic [N-1:0]     tok_data,
  input  logic [`AC_N-1:0] tok_op,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [`AC_N-1:0] alu_cmd,
  input  logic [N-1:0]     alu_c,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N-1:0]     res_data,
  output logic             res_err
);

  localparam logic [1:0] tk_num = 2'b00;
  localparam logic [1:0] tk_op  = 2'b01;
  localparam logic [1:0] tk_eq  = 2'b10;
  localparam logic [1:0] tk_clr = 2'b11;

  typedef enum logic [2:0] {
    st_empty, st_acc, st_op, st_exec, st_res
  } state_t;

  state_t             state_reg, state_next;
  logic [N-1:0]       acc_reg, acc_next;
  logic [N-1:0]       b_reg, b_next;
  logic [`AC_N-1:0]   op_reg, op_next;
  logic               tok_fire;

`ifdef DIV0_CHECK_EN
  logic err_reg, err_next;
  assign res_err = err_reg;
`else
  assign res_err = 1'b0;
`endif

  assign tok_fire = tok_valid & tok_ready;

  // ALU inputs come straight from registers so they never glitch during EXEC
  assign alu_a    = acc_reg;
  assign alu_b    = b_reg;
  assign alu_cmd  = op_reg;
  assign res_data = acc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= st_empty;
      acc_reg   <= '0;
      b_reg     <= '0;
      op_reg    <= `AC_AD;
`ifdef DIV0_CHECK_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      b_reg     <= b_next;
      op_reg    <= op_next;
`ifdef DIV0_CHECK_EN
      err_reg   <= err_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    b_next     = b_reg;
    op_next    = op_reg;
`ifdef DIV0_CHECK_EN
    err_next   = err_reg;
`endif
    case (state_reg)
      st_empty: begin
        if (tok_fire && tok_type == tk_num) begin
          acc_next   = tok_data;
          state_next = st_acc;
        end
      end
      st_acc: begin
        if (tok_fire) begin
          case (tok_type)
            tk_num: acc_next = tok_data;
            tk_op: begin
              op_next    = tok_op;
              state_next = st_op;
            end
            tk_eq:   state_next = st_res;
            default: state_next = st_empty;
          endcase
        end
      end
      st_op: begin
        if (tok_fire) begin
          case (tok_type)
            tk_op: op_next = tok_op;
            tk_num: begin
              b_next     = tok_data;
              state_next = st_exec;
`ifdef DIV0_CHECK_EN
              // Divide by zero never reaches the ALU; report it instead
              if (op_reg == `AC_DI && tok_data == '0) begin
                acc_next   = '0;
                err_next   = 1'b1;
                state_next = st_res;
              end
`endif
            end
            tk_clr: begin
              acc_next   = '0;
              op_next    = `AC_AD;
              state_next = st_empty;
            end
            default: state_next = st_op;
          endcase
        end
      end
      st_exec: begin
        acc_next   = alu_c;
        state_next = st_res;
      end
      st_res: begin
        if (res_ready) begin
          state_next = res_err ? st_empty : st_acc;
`ifdef DIV0_CHECK_EN
          err_next   = 1'b0;
`endif
        end
      end
      default: state_next = st_empty;
    endcase
  end

  always_comb begin
    tok_ready = (state_reg == st_empty) || (state_reg == st_acc) || (state_reg == st_op);
    res_valid = (state_reg == st_res);
  end

endmodule

// File: tb/tb_alu_driver.sv
// Scoreboard bench for alu_driver with a behavioural combinational ALU model.
`ifndef AC_N
`define AC_N 2
`endif
`ifndef AC_AD
`define AC_AD 2'd0
`endif
`ifndef AC_SB
`define AC_SB 2'd1
`endif
`ifndef AC_MU
`define AC_MU 2'd2
`endif
`ifndef AC_DI
`define AC_DI 2'd3
`endif

module tb_alu_driver;
  localparam int N = 16;
  localparam logic [1:0] NUM = 2'b00, OPT = 2'b01, EQ = 2'b10, CLR = 2'b11;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tok_valid = 1'b0;
  logic             tok_ready;
  logic [1:0]       tok_type = NUM;
  logic [N-1:0]     tok_data = '0;
  logic [`AC_N-1:0] tok_op = `AC_AD;
  logic [N-1:0]     alu_a, alu_b, alu_c;
  logic [`AC_N-1:0] alu_cmd;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [N-1:0]     res_data;
  logic             res_err;

  typedef struct { int data; bit err; } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  alu_driver #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_type(tok_type),
    .tok_data(tok_data), .tok_op(tok_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_c(alu_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
  );

  always #5 clk = ~clk;

  // Reference ALU; divide by zero yields 0 here so the default build stays deterministic
  always_comb begin
    alu_c = '0;
    case (alu_cmd)
      `AC_AD: alu_c = alu_a + alu_b;
      `AC_SB: alu_c = alu_a - alu_b;
      `AC_MU: alu_c = N'($signed(alu_a) * $signed(alu_b));
      default: alu_c = (alu_b == '0) ? '0 : N'($signed(alu_a) / $signed(alu_b));
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int d, input bit e);
    exp_t x;
    x.data = d;
    x.err  = e;
    q.push_back(x);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [1:0] ty, input int d, input logic [1:0] op);
    bit took = 1'b0;
    tok_type  = ty;
    tok_data  = N'(d);
    tok_op    = op;
    tok_valid = 1'b1;
    for (int i = 0; i < 50 && !took; i++) begin
      @(negedge clk);
      took = tok_ready;
      @(posedge clk);
      #1;
    end
    tok_valid = 1'b0;
    check("tok_accept", int'(took), 1);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got data=%0d err=%0d expected none",
                 $signed(res_data), res_err);
      end else begin
        mon_e = q.pop_front();
        check("res_data", int'($signed(res_data)), mon_e.data);
        check("res_err", int'(res_err), int'(mon_e.err));
        $display("result data=%0d err=%0d", $signed(res_data), res_err);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    step(2);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_alu_a", int'(alu_a), 0);
    check("rst_alu_cmd", int'(alu_cmd), int'(`AC_AD));
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_tok_ready", int'(tok_ready), 1);
    check("rst_res_err", int'(res_err), 0);
    step(1);

    // 1: reset during EXEC aborts the operation
    send(NUM, 7, `AC_AD);
    send(OPT, 0, `AC_MU);
    send(NUM, 5, `AC_AD);
    check("t1_exec_cmd", int'(alu_cmd), int'(`AC_MU));
    rst_n = 1'b0;
    #2;
    check("t1_res_valid", int'(res_valid), 0);
    check("t1_alu_cmd", int'(alu_cmd), int'(`AC_AD));
    check("t1_alu_a", int'(alu_a), 0);
    step(1);
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_tok_ready", int'(tok_ready), 1);
    check("t1_no_valid", int'(res_valid), 0);
    step(1);

    // 2: 7 + 5, result held while sink stalls
    res_ready = 1'b0;
    send(NUM, 7, `AC_AD);
    send(OPT, 0, `AC_AD);
    push(12, 0);
    send(NUM, 5, `AC_AD);
    check("t2_exec_a", int'(alu_a), 7);
    check("t2_exec_b", int'(alu_b), 5);
    check("t2_exec_valid", int'(res_valid), 0);
    step(1);
    check("t2_lat_valid", int'(res_valid), 1);
    check("t2_lat_data", int'($signed(res_data)), 12);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("t2_hold_valid", int'(res_valid), 1);
      check("t2_hold_data", int'($signed(res_data)), 12);
    end
    res_ready = 1'b1;
    step(1);

    // 3: chained left-to-right evaluation
    send(OPT, 0, `AC_MU);
    push(-36, 0);
    send(NUM, -3, `AC_AD);
    send(OPT, 0, `AC_SB);
    push(-40, 0);
    send(NUM, 4, `AC_AD);
    push(-40, 0);
    send(EQ, 0, `AC_AD);

    // 4: last operator wins, EQ in OP is dropped
    send(NUM, 6, `AC_AD);
    send(OPT, 0, `AC_AD);
    send(OPT, 0, `AC_SB);
    push(4, 0);
    send(NUM, 2, `AC_AD);
    check("t4_exec_cmd", int'(alu_cmd), int'(`AC_SB));
    check("t4_exec_a", int'(alu_a), 6);
    send(OPT, 0, `AC_AD);
    send(EQ, 0, `AC_AD);
    step(3);
    check("t4_eq_dropped", int'(res_valid), 0);
    push(5, 0);
    send(NUM, 1, `AC_AD);

    // 5: divide by zero
    send(CLR, 0, `AC_AD);
    send(NUM, 9, `AC_AD);
    send(OPT, 0, `AC_DI);
`ifdef DIV0_CHECK_EN
    push(0, 1);
    send(NUM, 0, `AC_AD);
    check("t5_skip_valid", int'(res_valid), 1);
    check("t5_skip_err", int'(res_err), 1);
    send(EQ, 0, `AC_AD);
    step(3);
    check("t5_empty_no_res", int'(res_valid), 0);
`else
    push(0, 0);
    send(NUM, 0, `AC_AD);
    check("t5_exec_b", int'(alu_b), 0);
    check("t5_exec_cmd", int'(alu_cmd), int'(`AC_DI));
    check("t5_exec_valid", int'(res_valid), 0);
    push(0, 0);
    send(EQ, 0, `AC_AD);
`endif
    send(NUM, 2, `AC_AD);
    send(OPT, 0, `AC_AD);
    push(5, 0);
    send(NUM, 3, `AC_AD);
    send(NUM, -9, `AC_AD);
    send(OPT, 0, `AC_DI);
    push(-4, 0);
    send(NUM, 2, `AC_AD);

    // 6: CLR in OP, then tokens blocked during RES
    send(NUM, 3, `AC_AD);
    send(OPT, 0, `AC_AD);
    send(CLR, 0, `AC_AD);
    check("t6_clr_a", int'(alu_a), 0);
    send(EQ, 0, `AC_AD);
    step(3);
    check("t6_no_res", int'(res_valid), 0);
    res_ready = 1'b0;
    send(NUM, 1, `AC_AD);
    push(1, 0);
    send(EQ, 0, `AC_AD);
    tok_type  = NUM;
    tok_data  = N'(5);
    tok_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_blocked", int'(tok_ready), 0);
      check("t6_hold_data", int'($signed(res_data)), 1);
      @(posedge clk);
      #1;
    end
    tok_valid = 1'b0;
    res_ready = 1'b1;
    step(1);
    push(1, 0);
    send(EQ, 0, `AC_AD);

    step(5);
    check("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
